// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: burst request ports R/W plus the single byte-wide RAM port.
interface ram_port_arbiter_if #(parameter int AW = 16, parameter int DW = 8);
  logic          r_req;
  logic [AW-1:0] r_addr;
  logic [2:0]    r_len;
  logic          r_gnt;
  logic          r_vld;
  logic [DW-1:0] r_data;
  logic          r_done;
  logic          w_req;
  logic [AW-1:0] w_addr;
  logic [2:0]    w_len;
  logic [DW-1:0] w_data;
  logic          w_gnt;
  logic          w_ack;
  logic          w_done;
  logic [AW-1:0] ram_a;
  logic          ram_we;
  logic [DW-1:0] ram_wd;
  logic [DW-1:0] ram_rd;
  modport slave (
    input  r_req, r_addr, r_len, w_req, w_addr, w_len, w_data, ram_rd,
    output r_gnt, r_vld, r_data, r_done, w_gnt, w_ack, w_done, ram_a, ram_we, ram_wd
  );
  modport master (
    output r_req, r_addr, r_len, w_req, w_addr, w_len, w_data, ram_rd,
    input  r_gnt, r_vld, r_data, r_done, w_gnt, w_ack, w_done, ram_a, ram_we, ram_wd
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: grants whole 1-8 byte read/write bursts on one RAM port.
// RAM_ARB_WR_PRIORITY_EN selects fixed W priority instead of round-robin.
module ram_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input logic clk,
  input logic rst_n,
  ram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, RD_TAIL, WR} state_t;
  state_t state;
  logic [2:0] cnt, len;
  logic pick_r, pick_w;
`ifdef RAM_ARB_WR_PRIORITY_EN
  assign pick_r = bus.r_req && !bus.w_req;
`else
  logic last_w;
  assign pick_r = bus.r_req && (!bus.w_req || last_w);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_w <= 1'b1;
    else if (state == IDLE && (pick_r || pick_w)) last_w <= pick_w;
`endif
  assign pick_w = bus.w_req && !pick_r;
  // ram_a is the live burst address; it stays put in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      len       <= '0;
      bus.ram_a <= '0;
      bus.r_vld <= 1'b0;
    end else begin
      bus.r_vld <= state == RD;
      if (state == IDLE) begin
        if (pick_r || pick_w) begin
          state     <= pick_r ? RD : WR;
          bus.ram_a <= pick_r ? bus.r_addr : bus.w_addr;
          len       <= pick_r ? bus.r_len : bus.w_len;
          cnt       <= '0;
        end
      end else if (state == RD_TAIL) begin
        state <= IDLE;
      end else if (cnt == len) begin
        state <= state == RD ? RD_TAIL : IDLE;
      end else begin
        cnt       <= cnt + 3'd1;
        bus.ram_a <= bus.ram_a + AW'(1);
      end
    end
  end
  assign bus.r_gnt  = state == RD || state == RD_TAIL;
  assign bus.r_done = state == RD_TAIL;
  assign bus.r_data = bus.r_vld ? bus.ram_rd : DW'(0);
  assign bus.w_gnt  = state == WR;
  assign bus.w_ack  = bus.w_gnt;
  assign bus.ram_we = bus.w_gnt;
  assign bus.w_done = bus.w_gnt && cnt == len;
  assign bus.ram_wd = bus.w_gnt ? bus.w_data : DW'(0);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bursts; a monitor checks RAM-side and port-side traffic against queued expectations.
module tb_ram_port_arbiter;
  typedef struct packed {logic [7:0] d; logic done;} rd_t;
  typedef struct packed {logic [15:0] a; logic [7:0] d; logic done;} wr_t;
  typedef struct packed {logic w; logic [3:0] n;} gnt_t;
  logic clk = 0, rst_n = 0;
  logic pre_we = 0;
  logic [15:0] pre_a = 0;
  logic [7:0] pre_d = 0;
  logic [7:0] mem [65536];
  int total = 0, bad = 0;
  int cur = 0, prv = 0, glen = 0;
  logic [15:0] exp_ra [$];
  rd_t exp_rd [$];
  wr_t exp_wr [$];
  gnt_t exp_gnt [$];
  ram_port_arbiter_if #(.AW(16), .DW(8)) bus ();
  ram_port_arbiter #(.AW(16), .DW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (bus.ram_we) mem[bus.ram_a] <= bus.ram_wd;
    bus.ram_rd <= mem[bus.ram_a];
  end
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask
  task automatic fail_now(input string n);
    total++;
    bad++;
    $display("FAIL %s got=event want=none", n);
  endtask
  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_we = 1;
    @(posedge clk); #1 pre_we = 0;
  endtask
  task automatic do_read(input logic [15:0] a, input logic [2:0] l, input logic [63:0] d);
    bit fin = 0;
    for (int k = 0; k <= int'(l); k++) begin
      exp_ra.push_back(a + 16'(k));
      exp_rd.push_back({d[8*k +: 8], k == int'(l)});
    end
    bus.r_addr = a; bus.r_len = l; bus.r_req = 1;
    for (int k = 0; k < 40 && !fin; k++) begin
      @(negedge clk);
      fin = bus.r_done;
    end
    @(posedge clk); #1 bus.r_req = 0;
    if (!fin) chk("rd_timeout", 0, 1);
  endtask
  task automatic do_write(input logic [15:0] a, input logic [2:0] l, input logic [63:0] d);
    bit fin = 0;
    int i = 0;
    for (int k = 0; k <= int'(l); k++) exp_wr.push_back({a + 16'(k), d[8*k +: 8], k == int'(l)});
    bus.w_addr = a; bus.w_len = l; bus.w_data = d[7:0]; bus.w_req = 1;
    for (int k = 0; k < 40 && !fin; k++) begin
      @(negedge clk);
      if (bus.w_ack) begin
        fin = bus.w_done;
        @(posedge clk); #1;
        i++;
        if (i < 8) bus.w_data = d[8*i +: 8];
      end
    end
    bus.w_req = 0;
    if (!fin) chk("wr_timeout", 0, 1);
  endtask
  function automatic logic [63:0] outs();
    return {bus.r_gnt, bus.w_gnt, bus.r_vld, bus.r_done, bus.w_ack, bus.w_done,
            bus.ram_we, bus.r_data, bus.ram_wd, bus.ram_a};
  endfunction
  always @(negedge clk) begin
    rd_t er;
    wr_t ew;
    gnt_t eg;
    chk("excl", (bus.r_gnt && bus.w_gnt) || (bus.r_done && bus.w_done), 0);
    if (bus.r_gnt && !bus.r_done) begin
      if (exp_ra.size() == 0) fail_now("rd_addr_extra");
      else chk("rd_addr", bus.ram_a, exp_ra.pop_front());
      chk("rd_we", bus.ram_we, 0);
    end
    if (bus.r_vld) begin
      if (exp_rd.size() == 0) fail_now("rd_data_extra");
      else begin
        er = exp_rd.pop_front();
        chk("rd_data", bus.r_data, er.d);
        chk("rd_done", bus.r_done, er.done);
      end
    end else if (bus.r_done) fail_now("rd_done_no_vld");
    if (bus.ram_we) begin
      if (exp_wr.size() == 0) fail_now("wr_extra");
      else begin
        ew = exp_wr.pop_front();
        chk("wr_addr", bus.ram_a, ew.a);
        chk("wr_data", bus.ram_wd, ew.d);
        chk("wr_done", bus.w_done, ew.done);
        chk("wr_ack", bus.w_ack, 1);
      end
    end else if (bus.w_ack || bus.w_done) fail_now("wr_ack_no_we");
    cur = bus.r_gnt ? 1 : bus.w_gnt ? 2 : 0;
    if (cur != prv) begin
      if (prv != 0) begin
        if (exp_gnt.size() == 0) fail_now("gnt_extra");
        else begin
          eg = exp_gnt.pop_front();
          chk("gnt_port", prv, eg.w ? 2 : 1);
          chk("gnt_len", glen, eg.n);
        end
      end
      glen = 0;
    end
    if (cur != 0) glen++;
    prv = cur;
  end
  initial begin
    bus.r_req = 0; bus.r_addr = 0; bus.r_len = 0;
    bus.w_req = 0; bus.w_addr = 0; bus.w_len = 0; bus.w_data = 0;
    for (int i = 0; i < 8; i++) poke(16'h0100 + 16'(i), 8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) poke(16'hFFFE + 16'(i), 8'hC0 + 8'(i));
    chk("reset_outs", outs(), 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
`ifdef RAM_ARB_WR_PRIORITY_EN
    exp_gnt.push_back({1'b1, 4'd1}); exp_gnt.push_back({1'b0, 4'd2});
`else
    exp_gnt.push_back({1'b0, 4'd2}); exp_gnt.push_back({1'b1, 4'd1});
`endif
    fork
      do_read(16'h0100, 3'd0, 64'h10);
      do_write(16'h3000, 3'd0, 64'h5A);
    join
    exp_gnt.push_back({1'b0, 4'd2});
    do_read(16'h0107, 3'd0, 64'h17);
    exp_gnt.push_back({1'b1, 4'd1}); exp_gnt.push_back({1'b0, 4'd2});
    fork
      do_read(16'h0105, 3'd0, 64'h15);
      do_write(16'h3001, 3'd0, 64'h6B);
    join
    exp_gnt.push_back({1'b0, 4'd9});
    do_read(16'h0100, 3'd7, 64'h1716151413121110);
    exp_gnt.push_back({1'b1, 4'd3});
    do_write(16'h2000, 3'd2, 64'hA3A2A1);
    exp_gnt.push_back({1'b0, 4'd4});
    do_read(16'h2000, 3'd2, 64'hA3A2A1);
    exp_gnt.push_back({1'b0, 4'd5});
    do_read(16'hFFFE, 3'd3, 64'hC3C2C1C0);
    for (int k = 0; k < 3; k++) exp_ra.push_back(16'h0100 + 16'(k));
    exp_rd.push_back({8'h10, 1'b0}); exp_rd.push_back({8'h11, 1'b0});
    exp_gnt.push_back({1'b0, 4'd3});
    bus.r_addr = 16'h0100; bus.r_len = 3'd7; bus.r_req = 1;
    repeat (4) @(posedge clk);
    #1 rst_n = 0; bus.r_req = 0;
    #1 chk("abort_outs", outs(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    exp_gnt.push_back({1'b0, 4'd3});
    do_read(16'h0104, 3'd1, 64'h1514);
    repeat (3) @(negedge clk);
    chk("left_ra", exp_ra.size(), 0);
    chk("left_rd", exp_rd.size(), 0);
    chk("left_wr", exp_wr.size(), 0);
    chk("left_gnt", exp_gnt.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end
endmodule
